// File: rtl/infix_to_postfix.sv
// Shunting-yard infix-to-postfix converter feeding the postfix evaluator.
// Buffers a whole expression, converts, then replays it as one gapless burst.
module infix_to_postfix #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_VALID,
  input  logic [3:0] IN,
  input  logic       OP_MODE,
  output logic       OUT_VALID,
  output logic [3:0] OUT,
  output logic       OUT_MODE,
  output logic       BUSY,
  output logic       ERROR
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE = PTR_W'(1);
  localparam logic [3:0] C_ADD = 4'b0001;
  localparam logic [3:0] C_SUB = 4'b0010;
  localparam logic [3:0] C_MUL = 4'b0100;
  localparam logic [3:0] C_LP  = 4'b1000;
  localparam logic [3:0] C_RP  = 4'b1001;

  typedef enum logic [2:0] {
    IDLE, CAPTURE, CONVERT, FLUSH, EMIT
  } state_t;

  state_t state, state_n;

  logic [4:0] ibuf [DEPTH];
  logic [4:0] q    [DEPTH];
  logic [3:0] stk  [DEPTH];

  logic [PTR_W-1:0] in_cnt, rd, sp, q_cnt, q_rd;
  logic [PTR_W-1:0] sp_m1, wr_ptr;
  logic             ovf, last, is_op, top_pops;
  logic [4:0]       tok, q_din, q_out;
  logic [3:0]       top;
  logic buf_wr, ovf_set, adv, push, pop, q_wr, emit, err;

  function automatic logic [1:0] prec(input logic [3:0] c);
    return (c == C_MUL) ? 2'd2 : 2'd1;
  endfunction

  assign BUSY     = (state != IDLE);
  assign sp_m1    = sp - ONE;
  assign wr_ptr   = (state == IDLE) ? '0 : in_cnt;
  assign tok      = ibuf[rd[IDX_W-1:0]];
  assign top      = stk[sp_m1[IDX_W-1:0]];
  assign q_out    = q[q_rd[IDX_W-1:0]];
  assign last     = (rd == in_cnt - ONE);
  assign is_op    = (tok[3:0] == C_ADD) || (tok[3:0] == C_SUB) ||
                    (tok[3:0] == C_MUL);
  assign top_pops = (sp != '0) && (top != C_LP) &&
                    (prec(top) >= prec(tok[3:0]));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    buf_wr  = 1'b0;
    ovf_set = 1'b0;
    adv     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    q_wr    = 1'b0;
    q_din   = tok;
    emit    = 1'b0;
    err     = 1'b0;
    unique case (state)
      IDLE: begin
        if (IN_VALID) begin
          buf_wr  = 1'b1;
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (IN_VALID) begin
          if (in_cnt == FULL) ovf_set = 1'b1;
          else                buf_wr  = 1'b1;
        end else if (ovf) begin
          err = 1'b1;
        end else begin
          state_n = CONVERT;
        end
      end
      CONVERT: begin
        if (!tok[4]) begin
          q_wr = 1'b1;
          adv  = 1'b1;
        end else if (tok[3:0] == C_LP) begin
          push = 1'b1;
          adv  = 1'b1;
        end else if (tok[3:0] == C_RP) begin
          if (sp == '0) begin
            err = 1'b1;
          end else if (top == C_LP) begin
            pop = 1'b1;
            adv = 1'b1;
          end else begin
            pop   = 1'b1;
            q_wr  = 1'b1;
            q_din = {1'b1, top};
          end
        end else if (is_op) begin
          if (top_pops) begin
            pop   = 1'b1;
            q_wr  = 1'b1;
            q_din = {1'b1, top};
          end else begin
            push = 1'b1;
            adv  = 1'b1;
          end
        end else begin
          adv = 1'b1;
        end
        if (adv && last) state_n = FLUSH;
      end
      FLUSH: begin
        if (sp == '0) begin
          if (q_cnt == '0) err = 1'b1;
          else             state_n = EMIT;
        end else if (top == C_LP) begin
          err = 1'b1;
        end else begin
          pop   = 1'b1;
          q_wr  = 1'b1;
          q_din = {1'b1, top};
        end
      end
      EMIT: begin
        if (q_rd == q_cnt) state_n = IDLE;
        else               emit    = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (err) state_n = IDLE;
  end

  // Storage arrays carry no reset; pointers alone define their contents.
  always_ff @(posedge CLK) begin
    if (buf_wr) ibuf[wr_ptr[IDX_W-1:0]] <= {OP_MODE, IN};
    if (push)   stk[sp[IDX_W-1:0]]      <= tok[3:0];
    if (q_wr)   q[q_cnt[IDX_W-1:0]]     <= q_din;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_cnt    <= '0;
      rd        <= '0;
      sp        <= '0;
      q_cnt     <= '0;
      q_rd      <= '0;
      ovf       <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT       <= '0;
      OUT_MODE  <= 1'b0;
      ERROR     <= 1'b0;
    end else begin
      ERROR     <= err;
      OUT_VALID <= emit;
      OUT       <= emit ? q_out[3:0] : 4'd0;
      OUT_MODE  <= emit & q_out[4];
      if (err) begin
        in_cnt <= '0;
        rd     <= '0;
        sp     <= '0;
        q_cnt  <= '0;
        q_rd   <= '0;
        ovf    <= 1'b0;
      end else begin
        if (state == IDLE) begin
          rd    <= '0;
          sp    <= '0;
          q_cnt <= '0;
          q_rd  <= '0;
          ovf   <= 1'b0;
        end
        if (buf_wr)  in_cnt <= wr_ptr + ONE;
        if (ovf_set) ovf    <= 1'b1;
        if (adv)     rd     <= rd + ONE;
        if (push)     sp <= sp + ONE;
        else if (pop) sp <= sp_m1;
        if (q_wr) q_cnt <= q_cnt + ONE;
        if (emit) q_rd  <= q_rd + ONE;
      end
    end
  end
endmodule

// File: doc/infix_to_postfix.md
Name: infix_to_postfix

Overview:
- Upstream stage of the postfix evaluator. Captures an infix token stream and converts it to postfix (shunting-yard).
- Replays the result as one contiguous OUT_VALID burst, in the token encoding the evaluator consumes: IN[3:0], with OP_MODE 0 = operand and 1 = operator.
- The evaluator clears its stack whenever its valid input drops, so output must never gap mid-expression. This block therefore buffers the full expression before emitting.

Parameters:
- DEPTH, 16, maximum tokens per expression, parentheses included. Sizes the input buffer, operator stack and output queue.
- PTR_W, 5, pointer/count width; must satisfy 2^PTR_W > DEPTH.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  token valid; one expression = one contiguous high run.
- IN  input  4  token value: operand 0..15, or operator code.
- OP_MODE  input  1  0 = operand, 1 = operator/paren.
- OUT_VALID  output  1  postfix token valid, contiguous burst.
- OUT  output  4  postfix token value.
- OUT_MODE  output  1  0 = operand, 1 = operator; drives evaluator OP_MODE.
- BUSY  output  1  high in every state except IDLE.
- ERROR  output  1  one-cycle pulse on malformed or oversize expression.

Behaviour:
- Token codes when OP_MODE=1:
  - 4'b0001 = +, 4'b0010 = -, 4'b0100 = *, 4'b1000 = '(', 4'b1001 = ')'.
  - Any other code is dropped during CONVERT.
- Precedence: * = 2; + and - = 1. All operators are left-associative.
- Reset (async, RESET=1): state IDLE, all pointers 0; OUT_VALID=0, OUT=0, OUT_MODE=0, BUSY=0, ERROR=0. Reset mid-operation aborts with no output.
- IDLE: IN_VALID=1 writes the token to the input buffer at index 0 and moves to CAPTURE.
- CAPTURE:
  - Each IN_VALID=1 cycle appends one token.
  - First IN_VALID=0 cycle moves to CONVERT.
  - Token number DEPTH+1 sets an overflow flag; the rest of the run is ignored.
  - On run end with overflow set: ERROR pulse, go to IDLE.
- CONVERT: at most one stack/queue action per cycle, reading the input buffer in order.
  - Operand: append to output queue; advance.
  - '(': push; advance.
  - ')':
    - Top is an operator: pop it to the queue; do not advance.
    - Top is '(': pop and discard it; advance.
    - Stack empty: ERROR.
  - Operator X:
    - Top is an operator with prec >= prec(X): pop it to the queue; do not advance.
    - Otherwise: push X; advance.
  - All input consumed: go to FLUSH.
- FLUSH:
  - Each cycle pops one operator to the queue.
  - Popping '(' gives ERROR (unmatched).
  - Stack empty: go to EMIT.
- EMIT:
  - Presents one queue entry per cycle, registered: OUT_VALID=1, OUT, OUT_MODE, with no gaps.
  - Cycle after the last entry: outputs return to 0, go to IDLE.
  - An empty queue (e.g. "()") gives ERROR and no burst.
- ERROR from any state: single-cycle pulse, discard all buffers, go to IDLE the same cycle. OUT_VALID is never asserted for a failed expression.
- Latency:
  - CONVERT takes one cycle per input token plus one per pop.
  - FLUSH takes one cycle per remaining operator plus one.
  - First OUT_VALID comes the cycle after EMIT is entered.
- IN_VALID while BUSY and not in CAPTURE is ignored (upstream must wait on BUSY=0). IN_VALID in the same cycle EMIT ends is ignored; the next expression starts from IDLE.
- No arithmetic is performed; operand values pass through unchanged.

Test Plan:
- 3 + 4 * 2 (tokens {0,3}{1,0001}{0,4}{1,0100}{0,2}) -> 5-cycle burst OUT=3,4,2,0100,0001 with OUT_MODE=0,0,0,1,1.
- ( 1 + 2 ) * 3 -> burst 1,2,0001,3,0100 with OUT_MODE 0,0,1,0,1; parens never emitted.
- 9 - 4 - 2 -> burst 9,4,0010,2,0010 (left associativity); second expression sent after BUSY falls converts independently.
- Malformed "1 )" and "( 1": ERROR one-cycle pulse, no OUT_VALID, BUSY low next cycle. 17-token run: ERROR, no burst.
- RESET pulsed mid-EMIT of 3+4*2: outputs 0 asynchronously; following 5*6 -> burst 5,6,0100 only.
- Single operand 7 -> one-cycle burst OUT=7, OUT_MODE=0.
